// File: rtl/base_wrr_arb.sv
// Weighted round-robin arbiter with packet-hold locking and a two-entry
// registered output stage that keeps i_r free of any path from o_r.
module base_wrr_arb #(
    parameter int unsigned width    = 1,
    parameter int unsigned ways     = 2,
    parameter int unsigned wt_width = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ways-1:0]           i_v,
    output logic [ways-1:0]           i_r,
    input  logic [ways-1:0]           i_h,
    input  logic [ways*width-1:0]     i_d,
    input  logic [ways*wt_width-1:0]  i_wt,
    input  logic                      o_r,
    output logic                      o_v,
    output logic                      o_h,
    output logic [ways-1:0]           o_s,
    output logic [width-1:0]          o_d
);

    localparam int unsigned PTR_W = (ways > 1) ? $clog2(ways) : 1;

    typedef struct packed {
        logic             h;
        logic [width-1:0] d;
        logic [ways-1:0]  s;
    } beat_t;

    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [wt_width-1:0] cnt_q, cnt_d;
    logic                lock_q, lock_d;
    logic [PTR_W-1:0]    lock_w_q, lock_w_d;
    logic                main_v_q, main_v_d;
    beat_t               main_q, main_d;
    logic                skid_v_q, skid_v_d;
    beat_t               skid_q, skid_d;

    logic [width-1:0]    d_a  [ways];
    logic [wt_width-1:0] wt_a [ways];

    // Way 0 sits in the MSBs of the packed data and weight buses.
    for (genvar g = 0; g < ways; g++) begin : g_way
        assign d_a[g]  = i_d[(ways-1-g)*width +: width];
        assign wt_a[g] = i_wt[(ways-1-g)*wt_width +: wt_width];
    end

    logic             win_v;
    logic [PTR_W-1:0] win_w;
    logic [PTR_W-1:0] cand;
    int unsigned      scan_j;

    // Scan descending so the nearest way after ptr is the last to overwrite.
    always_comb begin
        win_v  = 1'b0;
        win_w  = ptr_q;
        cand   = ptr_q;
        scan_j = 0;
        if (lock_q) begin
            win_v = i_v[lock_w_q];
            win_w = lock_w_q;
        end else if (cnt_q != '0 && i_v[ptr_q]) begin
            win_v = 1'b1;
            win_w = ptr_q;
        end else begin
            for (int unsigned k = ways; k >= 1; k--) begin
                scan_j = 32'(ptr_q) + k;
                if (scan_j >= ways) scan_j = scan_j - ways;
                cand = PTR_W'(scan_j);
                if (i_v[cand]) begin
                    win_v = 1'b1;
                    win_w = cand;
                end
            end
        end
    end

    logic [ways-1:0] win_oh;
    logic            acc_rdy, accept, pop;
    beat_t           in_beat;

    always_comb begin
        win_oh        = '0;
        win_oh[win_w] = 1'b1;
    end

    assign acc_rdy   = ~skid_v_q;
    assign accept    = win_v & acc_rdy & ~reset;
    assign pop       = main_v_q & o_r;
    assign i_r       = win_oh & {ways{accept}};
    assign in_beat.h = i_h[win_w];
    assign in_beat.d = d_a[win_w];
    assign in_beat.s = win_oh;

    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        lock_d   = lock_q;
        lock_w_d = lock_w_q;
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (pop) begin
            main_v_d = skid_v_q;
            if (skid_v_q) main_d = skid_q;
            skid_v_d = 1'b0;
        end
        if (accept) begin
            if (main_v_d) begin
                skid_v_d = 1'b1;
                skid_d   = in_beat;
            end else begin
                main_v_d = 1'b1;
                main_d   = in_beat;
            end
            // Quantum bookkeeping happens only at packet ends.
            if (in_beat.h) begin
                lock_d   = 1'b1;
                lock_w_d = win_w;
            end else begin
                lock_d = 1'b0;
                if (win_w == ptr_q && cnt_q != '0) begin
                    cnt_d = cnt_q - wt_width'(1);
                end else begin
                    ptr_d = win_w;
                    cnt_d = wt_a[win_w];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= PTR_W'(ways - 1);
            cnt_q    <= '0;
            lock_q   <= 1'b0;
            lock_w_q <= '0;
            main_v_q <= 1'b0;
            main_q   <= '0;
            skid_v_q <= 1'b0;
            skid_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            lock_w_q <= lock_w_d;
            main_v_q <= main_v_d;
            main_q   <= main_d;
            skid_v_q <= skid_v_d;
            skid_q   <= skid_d;
        end
    end

    assign o_v = main_v_q;
    assign o_h = main_q.h;
    assign o_d = main_q.d;
    assign o_s = main_q.s;

endmodule

// File: tb/tb_base_wrr_arb.sv
// Bench for base_wrr_arb (4 ways, 8-bit data): hand vectors, corner sequences
// and random traffic against a queue-based reference model.
module tb_base_wrr_arb;

    localparam int unsigned WAYS = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned WTW  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [WAYS-1:0]       i_v, i_r, i_h;
    logic [WAYS*DW-1:0]    i_d;
    logic [WAYS*WTW-1:0]   i_wt;
    logic                  o_r, o_v, o_h;
    logic [WAYS-1:0]       o_s;
    logic [DW-1:0]         o_d;

    always #5 clk = ~clk;

    base_wrr_arb #(.width(DW), .ways(WAYS), .wt_width(WTW)) dut (
        .clk(clk), .reset(reset),
        .i_v(i_v), .i_r(i_r), .i_h(i_h), .i_d(i_d), .i_wt(i_wt),
        .o_r(o_r), .o_v(o_v), .o_h(o_h), .o_s(o_s), .o_d(o_d)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: arbiter state as integers, output buffer as a 2-deep queue.
    typedef struct {
        logic       h;
        logic [7:0] d;
        int         src;
    } mbeat_t;

    mbeat_t m_q[$];
    int     m_ptr   = 3;
    int     m_cnt   = 0;
    bit     m_lock  = 0;
    int     m_lockw = 0;

    function automatic logic [3:0] oh(input int w);
        logic [3:0] r;
        r = 4'b0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    function automatic int wt_of(input logic [15:0] wt, input int w);
        return int'(wt[(3-w)*4 +: 4]);
    endfunction

    function automatic logic [7:0] d_of(input logic [31:0] d, input int w);
        return d[(3-w)*8 +: 8];
    endfunction

    function automatic int m_winner(input logic [3:0] v);
        if (m_lock) return v[m_lockw] ? m_lockw : -1;
        if (m_cnt != 0 && v[m_ptr]) return m_ptr;
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    logic [3:0] c_ir, c_os;
    logic       c_ov, c_oh;
    logic [7:0] c_od;

    task automatic cycle(input logic rst, input logic [3:0] v, input logic [3:0] h,
                         input logic [31:0] d, input logic [15:0] wt, input logic ordy);
        int         w;
        bit         acc;
        logic [3:0] exp_ir;
        mbeat_t     b;
        reset = rst; i_v = v; i_h = h; i_d = d; i_wt = wt; o_r = ordy;
        @(negedge clk);
        c_ir = i_r; c_ov = o_v; c_oh = o_h; c_od = o_d; c_os = o_s;
        w      = m_winner(v);
        acc    = (w >= 0) && (m_q.size() < 2);
        exp_ir = (!rst && acc) ? oh(w) : 4'b0;
        check("model_i_r", c_ir, exp_ir);
        if (!rst) begin
            check("model_o_v", c_ov, (m_q.size() > 0));
            if (m_q.size() > 0) begin
                check("model_o_h", c_oh, m_q[0].h);
                check("model_o_d", c_od, m_q[0].d);
                check("model_o_s", c_os, oh(m_q[0].src));
            end
        end
        if (rst) begin
            m_q.delete();
            m_ptr = 3; m_cnt = 0; m_lock = 0; m_lockw = 0;
        end else begin
            if (ordy && m_q.size() > 0) void'(m_q.pop_front());
            if (acc) begin
                b.h = h[w]; b.d = d_of(d, w); b.src = w;
                m_q.push_back(b);
                if (h[w]) begin
                    m_lock = 1; m_lockw = w;
                end else begin
                    m_lock = 0;
                    if (w == m_ptr && m_cnt != 0) m_cnt--;
                    else begin
                        m_ptr = w;
                        m_cnt = wt_of(wt, w);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  h;
        logic        ordy;
        logic [15:0] wt;
        logic [3:0]  e_ir;
        logic        e_ov;
        logic        e_oh;
        logic [3:0]  e_os;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] h,
                                input logic ordy, input logic [15:0] wt, input int ir_w,
                                input logic ov, input logic ohb, input int os_w);
        vec_t r;
        r.rst = rst; r.v = v; r.h = h; r.ordy = ordy; r.wt = wt;
        r.e_ir = oh(ir_w); r.e_ov = ov; r.e_oh = ohb; r.e_os = oh(os_w);
        return r;
    endfunction

    localparam logic [31:0] DCONST = 32'hA0B1C2D3;

    initial begin
        int wseq[11];
        int wc_exp[8];
        wseq   = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1};
        wc_exp = '{0, 0, 0, 1, 2, 3, 0, 1};

        // Plain round-robin at full rate, then a 5-cycle output stall.
        tv.push_back(mk(1, 4'hF, 4'h0, 1, 16'h0, -1, 0, 0, -1));
        tv.push_back(mk(0, 4'hF, 4'h0, 1, 16'h0, 0, 0, 0, -1));
        tv.push_back(mk(0, 4'hF, 4'h0, 1, 16'h0, 1, 1, 0, 0));
        tv.push_back(mk(0, 4'hF, 4'h0, 1, 16'h0, 2, 1, 0, 1));
        tv.push_back(mk(0, 4'hF, 4'h0, 1, 16'h0, 3, 1, 0, 2));
        tv.push_back(mk(0, 4'hF, 4'h0, 1, 16'h0, 0, 1, 0, 3));
        tv.push_back(mk(0, 4'hF, 4'h0, 1, 16'h0, 1, 1, 0, 0));
        tv.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 2, 1, 0, 1));
        for (int i = 0; i < 4; i++) tv.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, -1, 1, 0, 1));
        tv.push_back(mk(0, 4'hF, 4'h0, 1, 16'h0, -1, 1, 0, 1));
        tv.push_back(mk(0, 4'hF, 4'h0, 1, 16'h0, 3, 1, 0, 2));
        tv.push_back(mk(0, 4'hF, 4'h0, 1, 16'h0, 0, 1, 0, 3));
        // Three-beat packet on way 1 with a valid bubble mid-packet.
        tv.push_back(mk(1, 4'h7, 4'h0, 1, 16'h0, -1, 0, 0, -1));
        tv.push_back(mk(0, 4'h7, 4'h2, 1, 16'h0, 0, 0, 0, -1));
        tv.push_back(mk(0, 4'h7, 4'h2, 1, 16'h0, 1, 1, 0, 0));
        tv.push_back(mk(0, 4'h5, 4'h0, 1, 16'h0, -1, 1, 1, 1));
        tv.push_back(mk(0, 4'h7, 4'h2, 1, 16'h0, 1, 0, 0, -1));
        tv.push_back(mk(0, 4'h7, 4'h0, 1, 16'h0, 1, 1, 1, 1));
        tv.push_back(mk(0, 4'h7, 4'h0, 1, 16'h0, 2, 1, 0, 1));
        tv.push_back(mk(0, 4'h7, 4'h0, 1, 16'h0, 0, 1, 0, 2));
        // Weighted rotation with weights {2,0,1,0}.
        tv.push_back(mk(1, 4'hF, 4'h0, 1, 16'h2010, -1, 0, 0, -1));
        for (int k = 0; k < 11; k++)
            tv.push_back(mk(0, 4'hF, 4'h0, 1, 16'h2010, wseq[k], (k > 0), 0,
                            (k > 0) ? wseq[(k > 0) ? k-1 : 0] : -1));

        // Reset state.
        cycle(1, 4'h0, 4'h0, 32'h0, 16'h0, 1);
        check("rst_i_r", c_ir, 4'b0);
        cycle(0, 4'h0, 4'h0, 32'h0, 16'h0, 1);
        check("rst_o_v", c_ov, 1'b0);
        check("rst_o_h", c_oh, 1'b0);
        check("rst_o_d", c_od, 8'h0);
        check("rst_o_s", c_os, 4'h0);

        foreach (tv[i]) begin
            cycle(tv[i].rst, tv[i].v, tv[i].h, DCONST, tv[i].wt, tv[i].ordy);
            check($sformatf("vec%0d_i_r", i), c_ir, tv[i].e_ir);
            if (!tv[i].rst) begin
                check($sformatf("vec%0d_o_v", i), c_ov, tv[i].e_ov);
                if (tv[i].e_ov) begin
                    check($sformatf("vec%0d_o_s", i), c_os, tv[i].e_os);
                    check($sformatf("vec%0d_o_h", i), c_oh, tv[i].e_oh);
                end
            end
        end

        // Reset while way 2 is locked with two beats buffered.
        cycle(1, 4'h0, 4'h0, DCONST, 16'h0, 0);
        cycle(0, 4'h4, 4'h4, DCONST, 16'h0, 0);
        check("rmp_first", c_ir, 4'h4);
        cycle(0, 4'h4, 4'h4, DCONST, 16'h0, 0);
        check("rmp_skid", c_ir, 4'h4);
        cycle(0, 4'h4, 4'h4, DCONST, 16'h0, 0);
        check("rmp_full", c_ir, 4'h0);
        check("rmp_full_ov", c_ov, 1'b1);
        check("rmp_full_os", c_os, 4'h4);
        cycle(1, 4'hF, 4'h0, DCONST, 16'h0, 0);
        check("rmp_in_rst", c_ir, 4'h0);
        cycle(0, 4'hF, 4'h0, DCONST, 16'h0, 1);
        check("rmp_after_ov", c_ov, 1'b0);
        check("rmp_after_grant", c_ir, 4'h1);

        // Way 0 weight drops from 3 to 0 after its first packet.
        cycle(1, 4'h0, 4'h0, DCONST, 16'h3000, 1);
        cycle(0, 4'hF, 4'h0, DCONST, 16'h3000, 1);
        check("wchg_0", c_ir, 4'h1);
        for (int k = 0; k < 8; k++) begin
            cycle(0, 4'hF, 4'h0, DCONST, 16'h0000, 1);
            check($sformatf("wchg_%0d", k + 1), c_ir, oh(wc_exp[k]));
        end

        // Random traffic against the model.
        begin
            logic [15:0] wt_r;
            logic        rst_r;
            wt_r = 16'(32'($urandom));
            cycle(1, 4'h0, 4'h0, 32'h0, wt_r, 1);
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 49) == 0) wt_r = 16'(32'($urandom));
                rst_r = ($urandom_range(0, 199) == 0);
                cycle(rst_r, 4'(32'($urandom)), 4'(32'($urandom)), 32'($urandom), wt_r,
                      ($urandom_range(0, 3) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
